// File: rtl/hazard_ctrl_if.sv
// Pipeline/hazard-unit signal bundle: ID operands, EX/MEM destinations and the stall/flush controls.
interface hazard_ctrl_if;
  logic [4:0]  ifid_rs1addr, ifid_rs2addr;
  logic        ifid_rs1use, ifid_rs2use, ifid_isbranch, br_taken;
  logic [4:0]  idex_rdaddr, exmem_rdaddr;
  logic        idex_rdwren, idex_memrd, exmem_rdwren, exmem_memrd;
  logic        i_dmem_stall;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, o_hold;
  logic [15:0] stall_cnt, flush_cnt;

  // master: the pipeline, which supplies hazard info and obeys the controls
  modport master (
    output ifid_rs1addr, ifid_rs2addr, ifid_rs1use, ifid_rs2use, ifid_isbranch, br_taken,
           idex_rdaddr, idex_rdwren, idex_memrd, exmem_rdaddr, exmem_rdwren, exmem_memrd,
           i_dmem_stall,
    input  pc_en, ifid_en, ifid_flush, idex_flush, o_hold, stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_rs1addr, ifid_rs2addr, ifid_rs1use, ifid_rs2use, ifid_isbranch, br_taken,
           idex_rdaddr, idex_rdwren, idex_memrd, exmem_rdaddr, exmem_rdwren, exmem_memrd,
           i_dmem_stall,
    output pc_en, ifid_en, ifid_flush, idex_flush, o_hold, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard unit: stalls, bubbles and redirect flushes for a 5-stage pipe.
module hazard_ctrl (
  input  logic         i_clk,
  input  logic         i_rst,
  hazard_ctrl_if.slave hz
);
  typedef enum logic {RUN, HOLD} state_t;
  state_t state, state_nxt;

  logic ex1, ex2, mem1, mem2, ldex, ldmem;
  logic [1:0] need;
  logic hz_stall, redirect;
  logic pc_en, ifid_en, ifid_flush, idex_flush;
  logic [15:0] stall_cnt, flush_cnt;

  assign ex1  = hz.ifid_rs1use && hz.idex_rdwren && (hz.idex_rdaddr != 5'd0) &&
                (hz.ifid_rs1addr == hz.idex_rdaddr);
  assign ex2  = hz.ifid_rs2use && hz.idex_rdwren && (hz.idex_rdaddr != 5'd0) &&
                (hz.ifid_rs2addr == hz.idex_rdaddr);
  assign mem1 = hz.ifid_rs1use && hz.exmem_rdwren && (hz.exmem_rdaddr != 5'd0) &&
                (hz.ifid_rs1addr == hz.exmem_rdaddr);
  assign mem2 = hz.ifid_rs2use && hz.exmem_rdwren && (hz.exmem_rdaddr != 5'd0) &&
                (hz.ifid_rs2addr == hz.exmem_rdaddr);
  assign ldex  = hz.idex_memrd  && (ex1 || ex2);
  assign ldmem = hz.exmem_memrd && (mem1 || mem2);

  // ALU results forward from EX/MEM; only loads (and loads feeding an ID-stage compare) stall
  always_comb begin
    need = 2'd0;
    if (hz.ifid_isbranch && ldex)                              need = 2'd2;
    else if ((!hz.ifid_isbranch && ldex) || (hz.ifid_isbranch && ldmem)) need = 2'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    hz_stall   = 1'b0;
    redirect   = 1'b0;
    if (i_rst) begin
      state_nxt  = RUN;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hz.i_dmem_stall) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else if (state == HOLD || need != 2'd0) begin
      // HOLD burns its one extra cycle regardless of what the hazard inputs now say
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      hz_stall   = 1'b1;
      state_nxt  = (state == RUN && need == 2'd2) ? HOLD : RUN;
    end else if (hz.br_taken) begin
      ifid_flush = 1'b1;
      redirect   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (redirect && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign hz.pc_en      = pc_en;
  assign hz.ifid_en    = ifid_en;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_flush = idex_flush;
  assign hz.o_hold     = (state == HOLD);
  assign hz.stall_cnt  = stall_cnt;
  assign hz.flush_cnt  = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change after negedge, outputs checked 1ns later.
module tb_hazard_ctrl;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;

  hazard_ctrl_if hz ();
  hazard_ctrl dut (.i_clk(i_clk), .i_rst(i_rst), .hz(hz));

  always #5 i_clk = ~i_clk;

  // ctl = {pc_en, ifid_en, ifid_flush, idex_flush, o_hold}
  localparam logic [4:0] C_RST = 5'b00110, C_NORM = 5'b11000, C_STALL = 5'b00010,
                         C_HSTL = 5'b00011, C_REDIR = 5'b11100, C_FRZ = 5'b00000,
                         C_FRZH = 5'b00001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] ctl, input logic [15:0] sc,
                         input logic [15:0] fc);
    chk({tag, "_ctl"}, {27'd0, hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_flush, hz.o_hold},
        {27'd0, ctl});
    chk({tag, "_stall"}, {16'd0, hz.stall_cnt}, {16'd0, sc});
    chk({tag, "_flush"}, {16'd0, hz.flush_cnt}, {16'd0, fc});
  endtask

  task automatic clr();
    hz.ifid_rs1addr = 0; hz.ifid_rs2addr = 0; hz.ifid_rs1use = 0; hz.ifid_rs2use = 0;
    hz.ifid_isbranch = 0; hz.br_taken = 0;
    hz.idex_rdaddr = 0; hz.idex_rdwren = 0; hz.idex_memrd = 0;
    hz.exmem_rdaddr = 0; hz.exmem_rdwren = 0; hz.exmem_memrd = 0;
    hz.i_dmem_stall = 0;
  endtask

  task automatic nxt();
    @(negedge i_clk);
  endtask

  task automatic ld_ex(input logic [4:0] r);
    hz.idex_memrd = 1; hz.idex_rdwren = 1; hz.idex_rdaddr = r;
  endtask

  task automatic ld_mem(input logic [4:0] r);
    hz.exmem_memrd = 1; hz.exmem_rdwren = 1; hz.exmem_rdaddr = r;
  endtask

  initial begin
    clr();
    #1 chk_all("reset", C_RST, 16'd0, 16'd0);
    nxt(); i_rst = 0;
    #1 chk_all("release", C_NORM, 16'd0, 16'd0);

    // load-use on rs1: one bubble, then the load sits in MEM and no longer blocks an ALU op
    nxt(); hz.ifid_rs1addr = 5; hz.ifid_rs1use = 1; ld_ex(5);
    #1 chk_all("lduse_stall", C_STALL, 16'd0, 16'd0);
    nxt(); clr(); hz.ifid_rs1addr = 5; hz.ifid_rs1use = 1; ld_mem(5);
    #1 chk_all("lduse_after", C_NORM, 16'd1, 16'd0);

    // branch after load: two stall cycles, second one in HOLD
    nxt(); clr(); hz.ifid_isbranch = 1; hz.ifid_rs1addr = 5; hz.ifid_rs1use = 1; ld_ex(5);
    #1 chk_all("brld_s1", C_STALL, 16'd1, 16'd0);
    nxt(); clr(); hz.ifid_isbranch = 1; hz.ifid_rs1addr = 5; hz.ifid_rs1use = 1; ld_mem(5);
    #1 chk_all("brld_s2", C_HSTL, 16'd2, 16'd0);
    nxt(); clr(); hz.ifid_isbranch = 1; hz.ifid_rs1addr = 5; hz.ifid_rs1use = 1;
    #1 chk_all("brld_done", C_NORM, 16'd3, 16'd0);

    // no-stall cases: x0 load, ALU dependency, rdwren=0, unused operand
    nxt(); clr(); hz.ifid_rs1use = 1; ld_ex(0);
    #1 chk_all("x0_load", C_NORM, 16'd3, 16'd0);
    nxt(); clr(); hz.ifid_rs1addr = 5; hz.ifid_rs1use = 1; hz.idex_rdwren = 1; hz.idex_rdaddr = 5;
    #1 chk_all("alu_dep", C_NORM, 16'd3, 16'd0);
    nxt(); clr(); hz.ifid_rs1addr = 5; hz.ifid_rs1use = 1; ld_ex(5); hz.idex_rdwren = 0;
    #1 chk_all("no_wren", C_NORM, 16'd3, 16'd0);
    nxt(); clr(); hz.ifid_rs1addr = 5; ld_ex(5);
    #1 chk_all("no_use", C_NORM, 16'd3, 16'd0);
    nxt(); clr(); hz.ifid_rs2addr = 7; hz.ifid_rs2use = 1; ld_mem(7);
    #1 chk_all("alu_mem_ld", C_NORM, 16'd3, 16'd0);
    nxt(); clr(); hz.ifid_rs2addr = 7; hz.ifid_rs2use = 1; ld_ex(7);
    #1 chk_all("rs2_lduse", C_STALL, 16'd3, 16'd0);

    // redirect collides with a need=1 stall: stall wins, redirect honoured next cycle
    nxt(); clr(); hz.ifid_isbranch = 1; hz.ifid_rs1addr = 9; hz.ifid_rs1use = 1;
    ld_mem(9); hz.br_taken = 1;
    #1 chk_all("redir_vs_stall", C_STALL, 16'd4, 16'd0);
    nxt(); clr(); hz.ifid_isbranch = 1; hz.ifid_rs1addr = 9; hz.ifid_rs1use = 1; hz.br_taken = 1;
    #1 chk_all("redir", C_REDIR, 16'd5, 16'd0);
    nxt(); clr();
    #1 chk_all("post_redir", C_NORM, 16'd5, 16'd1);

    // freeze in RUN with a pending hazard: nothing moves, counters hold
    nxt(); hz.ifid_rs1addr = 3; hz.ifid_rs1use = 1; ld_ex(3); hz.i_dmem_stall = 1;
    #1 chk_all("frz_run", C_FRZ, 16'd5, 16'd1);
    nxt();
    #1 chk_all("frz_run2", C_FRZ, 16'd5, 16'd1);

    // freeze while HOLD for 3 cycles, then one HOLD stall, then RUN
    nxt(); clr(); hz.ifid_isbranch = 1; hz.ifid_rs2addr = 4; hz.ifid_rs2use = 1; ld_ex(4);
    #1 chk_all("hold_enter", C_STALL, 16'd5, 16'd1);
    for (int i = 0; i < 3; i++) begin
      nxt(); clr(); hz.i_dmem_stall = 1; hz.br_taken = 1;
      #1 chk_all("frz_hold", C_FRZH, 16'd6, 16'd1);
    end
    nxt(); clr(); hz.br_taken = 1;
    #1 chk_all("hold_after_frz", C_HSTL, 16'd6, 16'd1);
    nxt(); clr();
    #1 chk_all("run_after_hold", C_NORM, 16'd7, 16'd1);

    // async reset mid-HOLD: takes effect without a clock edge
    nxt(); hz.ifid_isbranch = 1; hz.ifid_rs1addr = 6; hz.ifid_rs1use = 1; ld_ex(6);
    nxt(); clr();
    #1 chk_all("hold_pre_rst", C_HSTL, 16'd8, 16'd1);
    #1 i_rst = 1;
    #1 chk_all("async_rst", C_RST, 16'd0, 16'd0);
    nxt(); i_rst = 0;
    #1 chk_all("rst_release", C_NORM, 16'd0, 16'd0);

    // saturation: 65535 stall cycles pin the counter; one more must not wrap
    nxt(); hz.ifid_rs1addr = 2; hz.ifid_rs1use = 1; ld_ex(2);
    repeat (65535) @(negedge i_clk);
    #1 chk_all("sat_reach", C_STALL, 16'hFFFF, 16'd0);
    nxt();
    #1 chk_all("sat_hold", C_STALL, 16'hFFFF, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: i_clk in 1, single clock, all state on rising edge; i_rst in 1, asynchronous, active-high reset.
REQ-002 SHALL have ifid_rs1addr in 5 and ifid_rs2addr in 5: ID source register addresses.
REQ-003 SHALL have ifid_rs1use in 1 and ifid_rs2use in 1: ID instruction reads rs1/rs2.
REQ-004 SHALL have ifid_isbranch in 1: ID instruction compares operands in ID (branch/jalr).
REQ-005 SHALL have br_taken in 1: ID branch/jump resolved as redirect this cycle.
REQ-006 SHALL have idex_rdaddr in 5, idex_rdwren in 1, idex_memrd in 1: EX destination, write enable, load flag.
REQ-007 SHALL have exmem_rdaddr in 5, exmem_rdwren in 1, exmem_memrd in 1: MEM destination, write enable, load flag.
REQ-008 SHALL have i_dmem_stall in 1: data memory not ready; whole pipeline freezes.
REQ-009 SHALL have outputs pc_en 1, ifid_en 1, ifid_flush 1, idex_flush 1, o_hold 1 (FSM in HOLD), stall_cnt 16, flush_cnt 16.

Function
REQ-010 SHALL define match_ex(r,use) = use && idex_rdwren && idex_rdaddr!=0 && r==idex_rdaddr, and match_mem likewise with exmem_*.
REQ-011 SHALL define ldex = idex_memrd && (match_ex(rs1,rs1use) || match_ex(rs2,rs2use)); ldmem likewise with exmem_memrd and match_mem.
REQ-012 SHALL compute need: 2 if ifid_isbranch && ldex; 1 if (!ifid_isbranch && ldex) || (ifid_isbranch && ldmem); else 0. ALU results in EX/MEM are forwarded and cause no stall.
REQ-013 SHALL implement 2-state FSM {RUN, HOLD}; o_hold=1 only in HOLD.
REQ-014 Priority per cycle SHALL be: i_dmem_stall > hazard stall (RUN with need>0, or HOLD) > redirect > normal.
REQ-015 Freeze (i_dmem_stall=1): pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=0; FSM state and counters unchanged.
REQ-016 Hazard stall cycle: pc_en=0, ifid_en=0, idex_flush=1 (bubble), ifid_flush=0; br_taken ignored.
REQ-017 RUN transitions: need=2 -> HOLD; need=1 -> RUN (re-evaluated next cycle); need=0 -> RUN. Outputs are combinational from state and inputs (zero latency).
REQ-018 HOLD SHALL stall unconditionally for exactly one cycle, ignoring hazard inputs, then -> RUN.
REQ-019 Redirect (RUN, need=0, br_taken=1): pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=0.
REQ-020 Normal: pc_en=1, ifid_en=1, both flushes 0.
REQ-021 stall_cnt SHALL increment by 1 per hazard-stall cycle, flush_cnt by 1 per redirect cycle; both saturate at 0xFFFF, never wrap.
REQ-022 Hazard and redirect in the same cycle SHALL yield stall only; redirect is honoured when the branch re-evaluates after the stall.

Reset
REQ-023 While i_rst=1: FSM=RUN, stall_cnt=0, flush_cnt=0, o_hold=0, pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1.
REQ-024 Reset asserted mid-HOLD or mid-freeze SHALL abort immediately; first cycle after release is RUN with counters 0.
REQ-025 After release with no hazard: pc_en=1, ifid_en=1, flushes 0.

Verification
REQ-026 Load-use: idex_memrd=1, idex_rdaddr=5, ifid_rs1addr=5, rs1use=1, isbranch=0 -> one stall cycle (pc_en=0, idex_flush=1), stall_cnt=1, then pc_en=1.
REQ-027 Branch after load: same with isbranch=1, bubble then moves load to MEM (exmem_memrd=1, exmem_rdaddr=5) -> two stall cycles, o_hold=1 in second, stall_cnt=2.
REQ-028 x0 and ALU deps: idex_rdaddr=0 with memrd=1, or idex_memrd=0 with match -> no stall, stall_cnt stays 0.
REQ-029 Redirect vs stall: br_taken=1 with need=1 -> stall only, flush_cnt unchanged; next cycle need=0, br_taken=1 -> ifid_flush=1, flush_cnt=1.
REQ-030 Freeze in HOLD: i_dmem_stall=1 for 3 cycles while HOLD -> all outputs 0 except o_hold=1, counters frozen; after release one HOLD stall then RUN. Preload stall_cnt=0xFFFF, further stall -> remains 0xFFFF. Async i_rst mid-HOLD -> o_hold=0, counters 0 without clock edge.
